// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the shared memory port and
// the arbiter. The arbiter connects through the slave modport; the requesters
// and the memory (or a bench standing in for them) use the master modport.
//
// Handshake: a requester raises req_x and keeps it high, with its address and
// data, until done_x pulses for one cycle. gnt_x marks ownership of the port
// from the ACCESS entry edge through the done cycle. Address and write data are
// latched at ACCESS entry, so the requester may change them once granted.
// A request dropped after the grant does not cancel the access. Its done pulse
// still arrives. On the memory side, mem_en and mem_wr strobe for one cycle,
// and mem_rdata is sampled exactly LAT cycles after the mem_en cycle.
interface mem_port_arbiter_if;
    logic        req_if;
    logic [63:0] addr_if;
    logic        req_dm;
    logic        wr_dm;
    logic [63:0] addr_dm;
    logic [63:0] wdata_dm;
    logic        gnt_if;
    logic        gnt_dm;
    logic        done_if;
    logic        done_dm;
    logic [63:0] rdata;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    modport slave (
        input  req_if, addr_if, req_dm, wr_dm, addr_dm, wdata_dm, mem_rdata,
        output gnt_if, gnt_dm, done_if, done_dm, rdata, mem_sel, mem_en,
               mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_if, addr_if, req_dm, wr_dm, addr_dm, wdata_dm, mem_rdata,
        input  gnt_if, gnt_dm, done_if, done_dm, rdata, mem_sel, mem_en,
               mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (IF) and data
// memory (DM). DM has priority. IF is forced through after STARVE_MAX
// consecutive DM grants that found IF waiting. Each access holds the port for
// LAT+1 ACCESS cycles and one DONE cycle. The read data is registered at the
// end of the last ACCESS cycle.
module mem_port_arbiter #(
    parameter int LAT        = 2,  // 1..15
    parameter int STARVE_MAX = 4   // 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus,
    output logic [1:0]            dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  lat_cnt_q;
    logic [3:0]  starve_cnt_q;
    logic        sel_q;
    logic        gnt_if_q;
    logic        gnt_dm_q;
    logic        done_if_q;
    logic        done_dm_q;
    logic        busy_q;
    logic        mem_en_q;
    logic        mem_wr_q;
    logic [63:0] rdata_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;

    logic        elig_if;
    logic        elig_dm;
    logic        win_if;
    logic        win_dm;
    logic [3:0]  starve_cnt_d;

    // Arbitration: the owner finishing in DONE is masked so its still-high req
    // is not mistaken for a new request.
    always_comb begin
        elig_if      = bus.req_if && !(state_q == DONE && !sel_q);
        elig_dm      = bus.req_dm && !(state_q == DONE &&  sel_q);
        win_dm       = elig_dm && !(starve_cnt_q == 4'(STARVE_MAX) && elig_if);
        win_if       = !win_dm && elig_if;
        starve_cnt_d = starve_cnt_q;
        if (win_if || !elig_if) begin
            starve_cnt_d = 4'd0;
        end else if (win_dm && starve_cnt_q < 4'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Port sequencer: arbitrate in IDLE/DONE, hold the access for LAT+1 cycles,
    // capture read data and pulse done for the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            sel_q        <= 1'b0;
            gnt_if_q     <= 1'b0;
            gnt_dm_q     <= 1'b0;
            done_if_q    <= 1'b0;
            done_dm_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            rdata_q      <= 64'd0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            done_if_q <= 1'b0;
            done_dm_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (win_dm || win_if) begin
                        state_q     <= ACCESS;
                        lat_cnt_q   <= 4'd0;
                        sel_q       <= win_dm;
                        gnt_dm_q    <= win_dm;
                        gnt_if_q    <= win_if;
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= win_dm && bus.wr_dm;
                        mem_addr_q  <= win_dm ? bus.addr_dm  : bus.addr_if;
                        mem_wdata_q <= win_dm ? bus.wdata_dm : 64'd0;
                    end else begin
                        state_q  <= IDLE;
                        gnt_if_q <= 1'b0;
                        gnt_dm_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    lat_cnt_q <= lat_cnt_q + 4'd1;
                    if (lat_cnt_q == 4'(LAT)) begin
                        state_q   <= DONE;
                        rdata_q   <= bus.mem_rdata;
                        done_if_q <= !sel_q;
                        done_dm_q <= sel_q;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gnt_if_q <= 1'b0;
                    gnt_dm_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_if    = gnt_if_q;
    assign bus.gnt_dm    = gnt_dm_q;
    assign bus.done_if   = done_if_q;
    assign bus.done_dm   = done_dm_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random
// requester traffic. A cycle-level reference model tracks the expected port
// owner, access position, starvation count and latched bus values.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int SM  = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: position within the current access (-1 idle,
    // 0..LAT access, LAT+1 done)
    int          m_pos;
    bit          m_own_dm;
    int          m_starve;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    bit          m_wr;
    bit          m_sel;
    int          mem_age;

    function automatic logic [63:0] mem_fn(logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32] ^ 32'h0BAD_F00D};
    endfunction

    task automatic model_reset();
        m_pos = -1; m_own_dm = 0; m_starve = 0; m_addr = '0;
        m_wdata = '0; m_rdata = '0; m_wr = 0; m_sel = 0;
    endtask

    // advance the model across one rising edge, using the inputs present
    // before that edge
    task automatic model_edge();
        bit e_if, e_dm, w_if, w_dm;
        if (!rst_n) begin
            model_reset();
        end else if (m_pos == -1 || m_pos == LAT + 1) begin
            e_if = bus.req_if && !(m_pos == LAT + 1 && !m_own_dm);
            e_dm = bus.req_dm && !(m_pos == LAT + 1 &&  m_own_dm);
            w_dm = e_dm && !(m_starve == SM && e_if);
            w_if = !w_dm && e_if;
            if (w_if || !e_if) m_starve = 0;
            else if (m_starve < SM) m_starve = m_starve + 1;
            if (w_dm || w_if) begin
                m_pos    = 0;
                m_own_dm = w_dm;
                m_sel    = w_dm;
                m_addr   = w_dm ? bus.addr_dm : bus.addr_if;
                m_wdata  = w_dm ? bus.wdata_dm : 64'd0;
                m_wr     = w_dm && bus.wr_dm;
            end else begin
                m_pos = -1;
            end
        end else begin
            if (m_pos == LAT) m_rdata = mem_fn(m_addr);
            m_pos = m_pos + 1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = (m_pos >= 0);
        chk("gnt_if",    64'(bus.gnt_if),  64'(act && !m_own_dm));
        chk("gnt_dm",    64'(bus.gnt_dm),  64'(act &&  m_own_dm));
        chk("done_if",   64'(bus.done_if), 64'(m_pos == LAT + 1 && !m_own_dm));
        chk("done_dm",   64'(bus.done_dm), 64'(m_pos == LAT + 1 &&  m_own_dm));
        chk("mem_en",    64'(bus.mem_en),  64'(m_pos == 0));
        chk("mem_wr",    64'(bus.mem_wr),  64'(m_pos == 0 && m_wr));
        chk("mem_sel",   64'(bus.mem_sel), 64'(m_sel));
        chk("busy",      64'(bus.busy),    64'(act));
        chk("mem_addr",  bus.mem_addr,     m_addr);
        chk("mem_wdata", bus.mem_wdata,    m_wdata);
        chk("rdata",     bus.rdata,        m_rdata);
        chk("dbg_state", 64'(dbg_state),
            (m_pos < 0) ? 64'd0 : (m_pos == LAT + 1) ? 64'd2 : 64'd1);
    endtask

    // memory stand-in: data is valid only LAT cycles after the strobe
    task automatic mem_update();
        if (!rst_n)           mem_age = -1;
        else if (bus.mem_en)  mem_age = 0;
        else if (mem_age >= 0) mem_age = mem_age + 1;
        bus.mem_rdata = (mem_age == LAT) ? mem_fn(bus.mem_addr)
                                         : {32'hBADB_AD00, 32'(mem_age)};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        mem_update();
    endtask

    task automatic run_n(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // driver: random requester behaviour after one cycle of observation
    task automatic drive_random();
        if (bus.done_if || (!bus.req_if && $urandom_range(0, 2) == 0)) begin
            bus.req_if  = ($urandom_range(0, 1) == 1);
            bus.addr_if = {$urandom, $urandom};
        end else if (bus.req_if && bus.gnt_if && $urandom_range(0, 15) == 0) begin
            bus.req_if = 1'b0;
        end
        if (bus.done_dm || (!bus.req_dm && $urandom_range(0, 2) == 0)) begin
            bus.req_dm = ($urandom_range(0, 3) != 0);
        end else if (bus.req_dm && bus.gnt_dm && $urandom_range(0, 15) == 0) begin
            bus.req_dm = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
            bus.wr_dm    = $urandom_range(0, 1) == 1;
            bus.addr_dm  = {$urandom, $urandom};
            bus.wdata_dm = {$urandom, $urandom};
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req_if = 0; bus.addr_if = '0; bus.req_dm = 0; bus.wr_dm = 0;
        bus.addr_dm = '0; bus.wdata_dm = '0; bus.mem_rdata = '0;
        mem_age = -1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_outputs();
        run_n(2);
        #2 rst_n = 1'b1;

        // single IF read
        bus.req_if = 1; bus.addr_if = 64'h100;
        step();
        chk("t1_gnt_if", 64'(bus.gnt_if), 64'd1);
        chk("t1_mem_addr", bus.mem_addr, 64'h100);
        run_n(3);
        chk("t1_done_if", 64'(bus.done_if), 64'd1);
        chk("t1_rdata", bus.rdata, mem_fn(64'h100));
        bus.req_if = 0;
        run_n(3);

        // DM store
        bus.req_dm = 1; bus.wr_dm = 1; bus.addr_dm = 64'h40; bus.wdata_dm = 64'h1234;
        step();
        chk("t2_mem_wr", 64'(bus.mem_wr), 64'd1);
        chk("t2_mem_wdata", bus.mem_wdata, 64'h1234);
        run_n(3);
        chk("t2_done_dm", 64'(bus.done_dm), 64'd1);
        bus.req_dm = 0; bus.wr_dm = 0;
        run_n(3);

        // contention: DM first, IF in the following slot
        bus.req_dm = 1; bus.addr_dm = 64'h80; bus.req_if = 1; bus.addr_if = 64'h200;
        run_n(4);
        chk("t3_done_dm", 64'(bus.done_dm), 64'd1);
        bus.req_dm = 0;
        step();
        chk("t3_gnt_if", 64'(bus.gnt_if), 64'd1);
        run_n(3);
        chk("t3_done_if", 64'(bus.done_if), 64'd1);
        bus.req_if = 0;
        run_n(2);

        // address change mid-access must not reach the port
        bus.req_dm = 1; bus.addr_dm = 64'h40;
        run_n(2);
        bus.addr_dm = 64'hFFFF;
        step();
        chk("t4_addr_hold", bus.mem_addr, 64'h40);
        run_n(2);
        bus.req_dm = 0;
        run_n(2);

        // both requesters held high continuously
        bus.req_dm = 1; bus.req_if = 1;
        run_n(24);
        bus.req_dm = 0; bus.req_if = 0;
        run_n(5);

        // reset in the middle of an access
        bus.req_if = 1; bus.addr_if = 64'h300;
        run_n(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        mem_update();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("t6_regrant", 64'(bus.gnt_if), 64'd1);
        run_n(4);
        bus.req_if = 0;
        run_n(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared 64-bit memory port between the instruction-fetch and data-memory stages of the pipelined LEGv8 core. Arbitrates between the two requesters and drives the select of the 64-bit 2:1 address/write-data muxes in front of the port. Holds the selected access for the memory's fixed latency, registers the read data, and returns a one-cycle completion pulse to the winning requester. Data memory has priority, with a bounded-starvation override for fetch.

## Interface
- LAT, 2, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15
- STARVE_MAX, 4, consecutive DM grants with IF pending before IF is forced; legal range 1..15
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_if  in  1  fetch request; held high until `done_if`
- addr_if  in  64  fetch address
- req_dm  in  1  data request; held high until `done_dm`
- wr_dm  in  1  data request is a store
- addr_dm  in  64  data address
- wdata_dm  in  64  store data
- gnt_if / gnt_dm  out  1  owner of the port; high for the whole access, including the done cycle
- done_if / done_dm  out  1  one-cycle completion pulse
- rdata  out  64  registered read data; valid in the done cycle and held until the next capture
- mem_sel  out  1  mux select: 0 selects IF, 1 selects DM; held for the whole access
- mem_en  out  1  one-cycle access strobe
- mem_wr  out  1  store strobe; asserted with `mem_en` only
- mem_addr  out  64  muxed address, stable for the whole access
- mem_wdata  out  64  muxed write data; `wdata_dm` when DM owns the port, 0 otherwise
- mem_rdata  in  64  memory read data
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Arbitration happens in IDLE and DONE only. The winner enters ACCESS at the next edge.
- Winner selection:
  - DM if `req_dm`, unless `starve_cnt == STARVE_MAX` and `req_if`, in which case IF wins.
  - Otherwise IF if `req_if`.
  - Otherwise return to / stay in IDLE.
- A requester whose done pulse occurs this cycle is excluded from arbitration in that cycle. Its `req` is still high and must not restart the same access.
- At ACCESS entry, latch the owner and the muxed address/write data, so `mem_addr` and `mem_wdata` stay stable even if inputs change.
- `mem_en` and `mem_wr` are high in the first ACCESS cycle only.
- `lat_cnt` clears at entry and increments each ACCESS cycle. When it reaches LAT, capture `mem_rdata` into `rdata` and move to DONE.
- Stores also take LAT+2 cycles. `rdata` is captured regardless and is don't-care for stores.
- DONE lasts one cycle and pulses `done_<owner>`.
- `starve_cnt` (4 bits, saturating at STARVE_MAX):
  - increments on a DM grant while `req_if` is high;
  - clears on any IF grant, or on any arbitration with `req_if` low.
- A `req` dropped mid-access is ignored: the access completes and done still pulses.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `lat_cnt` = 0, `starve_cnt` = 0;
  - all outputs 0, including `rdata`, `mem_addr`, `mem_wdata`.
- Reset mid-access aborts the access with no done pulse. The first grant is possible one edge after `rst_n` rises.
- Request seen in cycle t (IDLE):
  - t+1: `gnt` and `mem_en` high;
  - t+1+LAT: capture edge at the end of this cycle;
  - t+2+LAT: done pulse, `rdata` valid.
- Back-to-back: arbitration in the DONE cycle starts the next ACCESS at t+3+LAT. Sustained throughput is one access per LAT+2 cycles.
- Simultaneous `req_if` and `req_dm` in IDLE: DM wins unless starved.
- `mem_sel` changes only on the ACCESS entry edge. It never changes during ACCESS or DONE.

## Test plan
- Single IF read, LAT=2: `req_if`=1 with `addr_if`=0x100 at cycle 0, no DM request, memory returns 0xDEAD at cycle 3. Required: `gnt_if` at 1, `mem_en` only at 1, `mem_sel`=0, `mem_addr`=0x100 during 1-4, `done_if`=1 at cycle 4, `rdata`=0xDEAD from cycle 4.
- DM store: `req_dm`=1, `wr_dm`=1, `addr_dm`=0x40, `wdata_dm`=0x1234. Required: `mem_en`=1 and `mem_wr`=1 for exactly one cycle with `mem_wdata`=0x1234, `mem_sel`=1 throughout, `done_dm` four cycles after the request.
- Contention: both requests raised at cycle 0. Required: DM is granted first, `done_dm` at 4, `gnt_if` at 5, `done_if` at 8.
- Starvation, STARVE_MAX=4: `req_dm` held high continuously and `req_if` held high. Required: four DM accesses, then the fifth grant goes to IF, then `starve_cnt` clears.
- Abort and input hold:
  - `rst_n` pulled low during ACCESS. Required: all outputs 0 immediately, no done pulse, clean grant after release.
  - `addr_dm` changed mid-access. Required: `mem_addr` unchanged.
